// File: rtl/spi_master_if.sv
// Control-side handshake bundle for spi_master: request/address/data in,
// read data and status back out.
interface spi_master_if;
    logic       start;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;
    logic       done;

    modport master (
        output start, addr, rw, wdata,
        input  rdata, busy, done
    );

    modport slave (
        input  start, addr, rw, wdata,
        output rdata, busy, done
    );
endinterface

// File: rtl/spi_master.sv
// SPI initiator for one 16-bit frame: {addr[6:0], rw, data[7:0]}, MSB first,
// SCLK idles low, MOSI changes after SCLK fall, MISO sampled on SCLK rise.
module spi_master #(
    parameter int CLKS_PER_HALF = 5
) (
    input  logic         clk,
    input  logic         reset,
    spi_master_if.slave  bus,
    output logic         sclk_pin,
    output logic         cs_pin,
    output logic         mosi_pin,
    input  logic         miso_pin
);

    localparam int CW = $clog2(CLKS_PER_HALF) + 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        HIGH,
        LOW,
        TRAIL,
        GAP
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [4:0]     bitCnt_q, bitCnt_d;
    logic [14:0]    txShift_q, txShift_d;
    logic [7:0]     rxShift_q, rxShift_d;
    logic           rw_q, rw_d;
    logic [7:0]     rdata_q, rdata_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           sclk_q, sclk_d;
    logic           cs_q, cs_d;
    logic           mosi_q, mosi_d;

    logic [15:0]    txFrame;
    logic           halfDone;

    assign txFrame  = {bus.addr, bus.rw, bus.rw ? 8'h00 : bus.wdata};
    assign halfDone = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bitCnt_q  <= '0;
            txShift_q <= '0;
            rxShift_q <= '0;
            rw_q      <= 1'b0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            mosi_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitCnt_q  <= bitCnt_d;
            txShift_q <= txShift_d;
            rxShift_q <= rxShift_d;
            rw_q      <= rw_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            cs_q      <= cs_d;
            mosi_q    <= mosi_d;
        end
    end

    // Every non-idle state lasts exactly one SCLK half-period; the counter
    // is reloaded on each state change and the state ends when it hits zero.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q - CW'(1);
        bitCnt_d  = bitCnt_q;
        txShift_d = txShift_q;
        rxShift_d = rxShift_q;
        rw_d      = rw_q;
        rdata_d   = rdata_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sclk_d    = sclk_q;
        cs_d      = cs_q;
        mosi_d    = mosi_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = cnt_q;
                if (bus.start) begin
                    txShift_d = txFrame[14:0];
                    rw_d      = bus.rw;
                    cs_d      = 1'b0;
                    mosi_d    = txFrame[15];
                    busy_d    = 1'b1;
                    cnt_d     = HALF_M1;
                    bitCnt_d  = '0;
                    state_d   = LEAD;
                end
            end
            LEAD, LOW: begin
                if (halfDone) begin
                    sclk_d    = 1'b1;
                    rxShift_d = {rxShift_q[6:0], miso_pin};
                    cnt_d     = HALF_M1;
                    state_d   = HIGH;
                end
            end
            HIGH: begin
                if (halfDone) begin
                    sclk_d   = 1'b0;
                    bitCnt_d = bitCnt_q + 5'd1;
                    cnt_d    = HALF_M1;
                    if (bitCnt_q == 5'd15) begin
                        state_d = TRAIL;
                    end else begin
                        mosi_d    = txShift_q[14];
                        txShift_d = {txShift_q[13:0], 1'b0};
                        state_d   = LOW;
                    end
                end
            end
            TRAIL: begin
                if (halfDone) begin
                    cs_d    = 1'b1;
                    mosi_d  = 1'b0;
                    cnt_d   = HALF_M1;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (halfDone) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    if (rw_q) begin
                        rdata_d = rxShift_q;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign sclk_pin  = sclk_q;
    assign cs_pin    = cs_q;
    assign mosi_pin  = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a behavioural SPI memory slave that
// records MOSI frames, drives MISO on reads and stores bytes on writes.
module tb_spi_master;

    localparam int H = 5;

    logic clk = 1'b0;
    logic reset;
    logic sclkPin, csPin, mosiPin;
    logic misoPin = 1'b0;

    spi_master_if bus ();

    spi_master #(.CLKS_PER_HALF(H)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .sclk_pin (sclkPin),
        .cs_pin   (csPin),
        .mosi_pin (mosiPin),
        .miso_pin (misoPin)
    );

    always #5 clk = ~clk;

    int nApplied = 0;
    int nMiscompare = 0;

    // Behavioural slave, evaluated on the falling system clock so it sees
    // settled pin values and updates MISO well before the next SCLK rise.
    logic [7:0]  mem [128];
    logic        prevSclk = 1'b0;
    logic        prevCs = 1'b1;
    int          slvBits = 0;
    logic [15:0] slvShift = '0;
    logic [6:0]  slvAddr = '0;
    logic        slvRw = 1'b0;
    logic [7:0]  slvByte = '0;
    logic [15:0] lastFrame = '0;
    int          lastBits = 0;
    logic        loadReq = 1'b0;
    logic [6:0]  loadAddr = '0;
    logic [7:0]  loadData = '0;

    always @(negedge clk) begin
        if (loadReq) mem[loadAddr] = loadData;
        if (csPin === 1'b1) begin
            if (prevCs === 1'b0) begin
                lastFrame = slvShift;
                lastBits  = slvBits;
                if (slvBits == 16 && !slvShift[8]) mem[slvShift[15:9]] = slvShift[7:0];
            end
            slvBits  = 0;
            slvShift = '0;
            misoPin  = 1'b0;
        end else if (csPin === 1'b0) begin
            if (sclkPin === 1'b1 && prevSclk === 1'b0) begin
                slvShift = {slvShift[14:0], mosiPin};
                slvBits++;
                if (slvBits == 8) begin
                    slvAddr = slvShift[7:1];
                    slvRw   = slvShift[0];
                    slvByte = mem[slvShift[7:1]];
                end
            end
            if (sclkPin === 1'b0 && prevSclk === 1'b1) begin
                if (slvBits >= 8 && slvBits < 16 && slvRw) misoPin = slvByte[15 - slvBits];
                else misoPin = 1'b0;
            end
        end
        prevSclk = sclkPin;
        prevCs   = csPin;
    end

    typedef struct {
        logic [6:0]  addr;
        logic        rw;
        logic [7:0]  wdata;
        logic        preload;
        logic [7:0]  loadVal;
        logic [15:0] expFrame;
        logic [7:0]  expRdata;
    } vec_t;

    vec_t vecs [6];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nApplied++;
        if (actual !== expected) begin
            nMiscompare++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] a, input logic r, input logic [7:0] w);
        @(negedge clk);
        bus.start = 1'b1;
        bus.addr  = a;
        bus.rw    = r;
        bus.wdata = w;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Called right after the accept edge; k counts edges since acceptance.
    task automatic measureFrame(output int csLow, output int doneAt, output int firstRise,
                                output int lastFall, output logic busyAfterAccept,
                                output logic busyAtDone);
        logic prevS;
        prevS           = sclkPin;
        csLow           = 0;
        doneAt          = -1;
        firstRise       = -1;
        lastFall        = -1;
        busyAtDone      = 1'b1;
        busyAfterAccept = bus.busy;
        for (int k = 0; k < 250 && doneAt < 0; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (csPin === 1'b0) csLow++;
            if (sclkPin === 1'b1 && prevS === 1'b0 && firstRise < 0) firstRise = k;
            if (sclkPin === 1'b0 && prevS === 1'b1) lastFall = k;
            prevS = sclkPin;
            if (bus.done === 1'b1) begin
                doneAt     = k;
                busyAtDone = bus.busy;
            end
        end
    endtask

    task automatic runVector(input vec_t v, input string tag);
        int csLow, doneAt, firstRise, lastFall;
        logic busyAcc, busyDone;
        if (v.preload) begin
            @(posedge clk);
            #1;
            loadAddr = v.addr;
            loadData = v.loadVal;
            loadReq  = 1'b1;
            @(posedge clk);
            #1;
            loadReq  = 1'b0;
        end
        applyStimulus(v.addr, v.rw, v.wdata);
        measureFrame(csLow, doneAt, firstRise, lastFall, busyAcc, busyDone);
        checkOutput({tag, " busy after accept"}, 32'(busyAcc), 32'd1);
        checkOutput({tag, " first sclk rise"}, 32'(firstRise), 32'(H));
        checkOutput({tag, " last sclk fall"}, 32'(lastFall), 32'(32 * H));
        checkOutput({tag, " cs low cycles"}, 32'(csLow), 32'(33 * H));
        checkOutput({tag, " done cycle"}, 32'(doneAt), 32'(34 * H));
        checkOutput({tag, " busy at done"}, 32'(busyDone), 32'd0);
        checkOutput({tag, " rdata"}, 32'(bus.rdata), 32'(v.expRdata));
        @(negedge clk);
        @(negedge clk);
        checkOutput({tag, " mosi frame"}, 32'(lastFrame), 32'(v.expFrame));
        checkOutput({tag, " bits clocked"}, 32'(lastBits), 32'd16);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        int csRise, csFall2, done1, done2;
        logic prevCsTb;

        vecs[0] = '{addr: 7'h2A, rw: 1'b0, wdata: 8'hFF, preload: 1'b0, loadVal: 8'h00, expFrame: 16'h54FF, expRdata: 8'h00};
        vecs[1] = '{addr: 7'h2A, rw: 1'b1, wdata: 8'h00, preload: 1'b1, loadVal: 8'hA5, expFrame: 16'h5500, expRdata: 8'hA5};
        vecs[2] = '{addr: 7'h05, rw: 1'b0, wdata: 8'h3C, preload: 1'b0, loadVal: 8'h00, expFrame: 16'h0A3C, expRdata: 8'hA5};
        vecs[3] = '{addr: 7'h05, rw: 1'b1, wdata: 8'hEE, preload: 1'b0, loadVal: 8'h00, expFrame: 16'h0B00, expRdata: 8'h3C};
        vecs[4] = '{addr: 7'h7F, rw: 1'b0, wdata: 8'h81, preload: 1'b0, loadVal: 8'h00, expFrame: 16'hFE81, expRdata: 8'h3C};
        vecs[5] = '{addr: 7'h7F, rw: 1'b1, wdata: 8'h00, preload: 1'b0, loadVal: 8'h00, expFrame: 16'hFF00, expRdata: 8'h81};

        bus.start = 1'b0;
        bus.addr  = '0;
        bus.rw    = 1'b0;
        bus.wdata = '0;
        reset     = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset cs", 32'(csPin), 32'd1);
        checkOutput("reset sclk", 32'(sclkPin), 32'd0);
        checkOutput("reset mosi", 32'(mosiPin), 32'd0);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset rdata", 32'(bus.rdata), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            runVector(vecs[i], $sformatf("vec%0d", i));
        end

        // Start pulsed mid-frame must be ignored; reset then aborts the frame.
        applyStimulus(7'h11, 1'b0, 8'h55);
        repeat (39) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.addr  = 7'h7F;
        bus.rw    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("midframe busy", 32'(bus.busy), 32'd1);
        checkOutput("midframe cs", 32'(csPin), 32'd0);
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort cs", 32'(csPin), 32'd1);
        checkOutput("abort sclk", 32'(sclkPin), 32'd0);
        checkOutput("abort mosi", 32'(mosiPin), 32'd0);
        checkOutput("abort busy", 32'(bus.busy), 32'd0);
        checkOutput("abort done", 32'(bus.done), 32'd0);
        checkOutput("abort rdata", 32'(bus.rdata), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("abort bits clocked", 32'(lastBits), 32'd6);
        checkOutput("abort partial frame", 32'(lastFrame[5:0]), 32'(6'b001000));
        runVector(vecs[5], "post-abort");

        // Start held high across two frames.
        @(negedge clk);
        bus.start = 1'b1;
        bus.addr  = 7'h05;
        bus.rw    = 1'b0;
        bus.wdata = 8'h99;
        csRise   = -1;
        csFall2  = -1;
        done1    = -1;
        done2    = -1;
        prevCsTb = 1'b1;
        for (int k = 0; k < 600 && done2 < 0; k++) begin
            @(posedge clk);
            #1;
            if (csPin === 1'b1 && prevCsTb === 1'b0 && csRise < 0) csRise = k;
            if (csPin === 1'b0 && prevCsTb === 1'b1 && csRise >= 0 && csFall2 < 0) begin
                csFall2   = k;
                bus.start = 1'b0;
            end
            prevCsTb = csPin;
            if (bus.done === 1'b1) begin
                if (done1 < 0) done1 = k;
                else done2 = k;
            end
        end
        bus.start = 1'b0;
        checkOutput("b2b first done", 32'(done1), 32'(34 * H));
        checkOutput("b2b cs high gap", 32'(csFall2 - csRise), 32'(H + 1));
        checkOutput("b2b done spacing", 32'(done2 - done1), 32'(34 * H + 1));
        repeat (2) @(negedge clk);
        checkOutput("b2b second frame", 32'(lastFrame), 32'h0A99);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("b2b no third frame", 32'(bus.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompare);
        $finish;
    end

endmodule
